cdc_stream_bridge: RTL and testbench
====================================

Name: cdc_stream_bridge

Overview:
- Buffered byte-stream bridge between the USB CDC receive port (recv_data/recv_valid, no backpressure) and the CDC send port (send_data/send_valid/send_ready).
- Replaces the direct unbuffered loopback that ignores send_ready and loses bytes.
- Adds a FIFO of parametrised depth, a selectable character transform, overflow detection and a fill level.
- Sits in the clk60 domain between usb_serial_top's receive and send sides.

Parameters:
- DATA_W, 8, byte width; transform applies only when DATA_W==8, else forced to passthrough.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- MODE, 1, reset-default transform: 0 passthrough, 1 lower->upper, 2 upper->lower, 3 swap case.

Ports:
- clk  in  1  system clock (clk60).
- rstn  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  received byte.
- in_valid  in  1  single-cycle strobe; byte present this cycle.
- out_data  out  DATA_W  FIFO head byte.
- out_valid  out  1  head byte available.
- out_ready  in  1  sink accepts (send_ready).
- mode_sel  in  2  runtime transform select; sampled on mode_we.
- mode_we  in  1  load mode_sel into the mode register.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a byte was dropped.
- overflow_clr  in  1  clears overflow.
- drop_cnt  out  16  dropped-byte counter (optional feature).
- hwm  out  $clog2(DEPTH)+1  high-water mark of level (optional feature).

Behaviour:
- Reset (rstn low, async), with no clock required:
  - out_valid=0; level=0; overflow=0; drop_cnt=0; hwm=0.
  - Read and write pointers = 0; mode register = MODE.
  - out_data=0 while empty.
- Transform is combinational on in_data, using the current mode register, and applied before the write:
  - Lowercase range is 0x61..0x7A; uppercase range is 0x41..0x5A.
  - lower->upper subtracts 0x20; upper->lower adds 0x20; swap does both; all other bytes pass unchanged.
- mode_we takes effect on bytes written from the next cycle on. Bytes already stored are not re-transformed.
- Storage is a flop array with first-word fall-through:
  - A byte written at the edge ending cycle N appears on out_data with out_valid=1 in cycle N+1, so latency is 1 cycle.
- Pop: out_valid && out_ready at an edge advances rd_ptr. out_ready while empty is ignored.
- out_data and out_valid stay stable while out_valid && !out_ready.
- Push: in_valid at an edge writes when level<DEPTH, or when level==DEPTH and a pop occurs the same edge. In the full case, push and pop proceed together and level is unchanged.
- Drop: in_valid with level==DEPTH and no pop:
  - The byte is discarded and pointers are unchanged.
  - overflow is set the same edge; it is visible in the next cycle.
- overflow_clr clears overflow. If a clear and a new drop coincide on the same edge, set wins.
- level is +1 on push only, -1 on pop only, and unchanged on both or neither.
- Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty, and the pointers wrap naturally.
- If rstn is asserted mid-stream, all stored data is discarded and no partial state survives.

Optional Feature:
- Macro: CDC_STREAM_BRIDGE_STATS_EN.
- Defined:
  - drop_cnt increments on every drop and saturates at 0xFFFF.
  - drop_cnt is cleared only by reset; overflow_clr does not affect it.
  - hwm registers max(hwm, level_next) every cycle.
- Undefined:
  - drop_cnt and hwm are tied to 0 and their counter logic is absent.
  - Ports remain present in both builds.

Decomposition:
- Package cdc_stream_pkg:
  - mode enum: MODE_PASS=0, MODE_UPPER=1, MODE_LOWER=2, MODE_SWAP=3.
  - Constants ASCII_LC_LO=0x61, ASCII_LC_HI=0x7A, ASCII_UC_LO=0x41, ASCII_UC_HI=0x5A, CASE_DELTA=0x20.
- One sub-module: char_xform, the purely combinational transform taking a data byte and a mode.
- FIFO control and counters stay in the top module.

Test Plan:
- Reset, then push 'a'(0x61) with MODE=1 and out_ready=1: out_valid=1 with out_data=0x41 exactly 1 cycle later; level returns to 0.
- out_ready=0, DEPTH=16, push 20 bytes 0x00..0x13:
  - level=16 and overflow=1.
  - drop_cnt=4 with STATS_EN; hwm=16.
  - Draining yields exactly 0x00..0x0F in order.
- Full FIFO with in_valid and out_ready on the same edge: the byte is accepted, level stays 16, no overflow, and the order is preserved across pointer wrap.
- mode_we with mode_sel=3, then push 'A','z','5': the outputs are 0x61, 0x5A, 0x35. Bytes stored before the mode change come out unmodified.
- Backpressure: out_ready toggles 0/1 randomly for 1000 bytes at a 50% in_valid rate with the FIFO never full. Output equals the transformed input sequence with no loss and no duplicates, and out_data is stable while stalled.
- overflow_clr asserted on the same edge as a drop leaves overflow=1. A clear alone gives overflow=0. Asserting rstn mid-stream zeroes level, out_valid and the counters immediately.

Source files
------------

// File: rtl/cdc_stream_pkg.sv
// Shared types and ASCII constants for the CDC byte-stream bridge.
package cdc_stream_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_UPPER = 2'd1,
    MODE_LOWER = 2'd2,
    MODE_SWAP  = 2'd3
  } mode_e;

  localparam logic [7:0] ASCII_LC_LO = 8'h61;
  localparam logic [7:0] ASCII_LC_HI = 8'h7A;
  localparam logic [7:0] ASCII_UC_LO = 8'h41;
  localparam logic [7:0] ASCII_UC_HI = 8'h5A;
  localparam logic [7:0] CASE_DELTA  = 8'h20;

endpackage

// File: rtl/char_xform.sv
// Purely combinational character-case transform. Only byte-wide data is
// treated as ASCII; any other width passes straight through.
module char_xform
  import cdc_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] din,
  input  mode_e             mode,
  output logic [DATA_W-1:0] dout
);

  if (DATA_W == 8) begin : g_ascii
    logic is_lc_s;
    logic is_uc_s;

    // Classify the byte and apply the selected case mapping.
    always_comb begin
      is_lc_s = (din >= ASCII_LC_LO) && (din <= ASCII_LC_HI);
      is_uc_s = (din >= ASCII_UC_LO) && (din <= ASCII_UC_HI);
      dout    = din;
      case (mode)
        MODE_UPPER: begin
          if (is_lc_s) dout = din - CASE_DELTA;
          else         dout = din;
        end
        MODE_LOWER: begin
          if (is_uc_s) dout = din + CASE_DELTA;
          else         dout = din;
        end
        MODE_SWAP: begin
          if (is_lc_s)      dout = din - CASE_DELTA;
          else if (is_uc_s) dout = din + CASE_DELTA;
          else              dout = din;
        end
        default: dout = din;
      endcase
    end
  end else begin : g_pass
    logic [1:0] unused_mode_s;
    assign unused_mode_s = mode;
    assign dout          = din;
  end

endmodule

// File: rtl/cdc_stream_bridge.sv
// Buffered byte-stream bridge between the CDC receive strobe and the
// send handshake: case transform, first-word-fall-through flop FIFO,
// sticky overflow and fill level. Define CDC_STREAM_BRIDGE_STATS_EN to
// build the drop counter and high-water mark; otherwise those ports read 0.
module cdc_stream_bridge
  import cdc_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int MODE   = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic [1:0]                 mode_sel,
  input  logic                       mode_we,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       overflow_clr,
  output logic [15:0]                drop_cnt,
  output logic [$clog2(DEPTH):0]     hwm
);

  localparam int    AW       = $clog2(DEPTH);
  localparam int    LW       = AW + 1;
  localparam mode_e MODE_RST = mode_e'(MODE[1:0]);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  mode_e             mode_q, mode_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] xform_s;
  logic              full_s, empty_s, pop_s, push_s, drop_s;

  char_xform #(.DATA_W(DATA_W)) u_xform (
    .din  (in_data),
    .mode (mode_q),
    .dout (xform_s)
  );

  assign full_s    = (level_q == LW'(DEPTH));
  assign empty_s   = (level_q == LW'(0));
  assign out_valid = !empty_s;
  assign pop_s     = out_valid && out_ready;
  assign push_s    = in_valid && (!full_s || pop_s);
  assign drop_s    = in_valid && full_s && !pop_s;
  assign level     = level_q;
  assign overflow  = overflow_q;

  // Present the head entry, forcing zero while the FIFO is empty.
  always_comb begin
    if (empty_s) out_data = '0;
    else         out_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next-state for pointers, occupancy, mode and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    mode_d     = mode_q;
    overflow_d = overflow_q;

    if (push_s) wr_ptr_d = wr_ptr_q + LW'(1);
    else        wr_ptr_d = wr_ptr_q;

    if (pop_s) rd_ptr_d = rd_ptr_q + LW'(1);
    else       rd_ptr_d = rd_ptr_q;

    if (push_s && !pop_s)      level_d = level_q + LW'(1);
    else if (pop_s && !push_s) level_d = level_q - LW'(1);
    else                       level_d = level_q;

    if (mode_we) mode_d = mode_e'(mode_sel);
    else         mode_d = mode_q;

    // A drop on the same edge as a clear keeps the flag set.
    if (drop_s)            overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      mode_q     <= MODE_RST;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      mode_q     <= mode_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are invisible once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q[AW-1:0]] <= xform_s;
  end

`ifdef CDC_STREAM_BRIDGE_STATS_EN
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [LW-1:0] hwm_q, hwm_d;

  // Saturating drop count and running maximum of the next occupancy.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    hwm_d      = hwm_q;
    if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    else                                    drop_cnt_d = drop_cnt_q;
    if (level_d > hwm_q) hwm_d = level_d;
    else                 hwm_d = hwm_q;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_q <= 16'd0;
      hwm_q      <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      hwm_q      <= hwm_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign hwm      = hwm_q;
`else
  assign drop_cnt = 16'd0;
  assign hwm      = '0;
`endif

endmodule

// File: tb/tb_cdc_stream_bridge.sv
// Directed scoreboard bench for cdc_stream_bridge (DATA_W=8, DEPTH=16, MODE=1).
module tb_cdc_stream_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  mode_sel;
  logic        mode_we;
  logic [4:0]  level;
  logic        overflow;
  logic        overflow_clr;
  logic [15:0] drop_cnt;
  logic [4:0]  hwm;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] sb[$];
  logic [1:0] m_mode;
  logic       m_ov;
  int         m_drops;
  int         m_hwm;
  logic       held_v;
  logic [7:0] held_d;

  cdc_stream_bridge dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mode_sel(mode_sel), .mode_we(mode_we), .level(level),
    .overflow(overflow), .overflow_clr(overflow_clr),
    .drop_cnt(drop_cnt), .hwm(hwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xf(input logic [7:0] d, input logic [1:0] m);
    logic lc, uc;
    lc = (d >= 8'h61) && (d <= 8'h7A);
    uc = (d >= 8'h41) && (d <= 8'h5A);
    case (m)
      2'd1:    return lc ? d - 8'h20 : d;
      2'd2:    return uc ? d + 8'h20 : d;
      2'd3:    return lc ? d - 8'h20 : (uc ? d + 8'h20 : d);
      default: return d;
    endcase
  endfunction

  function automatic int exp_drops();
`ifdef CDC_STREAM_BRIDGE_STATS_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_hwm();
`ifdef CDC_STREAM_BRIDGE_STATS_EN
    return m_hwm;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    sb.delete();
    m_mode  = 2'd1;
    m_ov    = 1'b0;
    m_drops = 0;
    m_hwm   = 0;
    held_v  = 1'b0;
  endtask

  // One clock: drive inputs, check current outputs, update model, cross edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic rdy,
                       input logic mwe, input logic [1:0] msel, input logic oclr);
    logic pop, full;
    in_valid = v; in_data = d; out_ready = rdy;
    mode_we = mwe; mode_sel = msel; overflow_clr = oclr;
    chk("level", 32'(level), 32'(sb.size()));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (held_v) chk("stall_stable", 32'(out_data), 32'(held_d));
    full = (sb.size() == 16);
    pop  = (sb.size() != 0) && rdy;
    held_v = (sb.size() != 0) && !rdy;
    if (held_v) held_d = sb[0];
    if (pop) chk("out_data", 32'(out_data), 32'(sb.pop_front()));
    if (v) begin
      if (!full || pop) sb.push_back(xf(d, m_mode));
      else begin
        m_ov = 1'b1;
        m_drops++;
      end
    end
    if (!(v && full && !pop) && oclr) m_ov = 1'b0;
    if (mwe) m_mode = msel;
    if (sb.size() > m_hwm) m_hwm = sb.size();
    @(posedge clk);
    #1;
    chk("overflow", 32'(overflow), 32'(m_ov));
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 8'h00, rdy, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) idle(1'b1);
    chk("drained_level", 32'(level), 32'd0);
  endtask

  initial begin
    int sent;
    logic [7:0] b;
    rstn = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    mode_sel = 2'd0; mode_we = 1'b0; overflow_clr = 1'b0;
    model_reset();

    // reset values before any clock edge
    #2;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_hwm", 32'(hwm), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    // 'a' with reset mode upper: 0x41 one cycle later
    drive(1'b1, 8'h61, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h41);
    idle(1'b1);
    chk("lat_level0", 32'(level), 32'd0);

    // 20 bytes with no sink: 16 kept, 4 dropped
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 2'd0, 1'b0);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_overflow", 32'(overflow), 32'd1);
    chk("fill_drop_cnt", 32'(drop_cnt), 32'(exp_drops()));
    chk("fill_hwm", 32'(hwm), 32'(exp_hwm()));

    // clear alone
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("clr_alone", 32'(overflow), 32'd0);

    // full with simultaneous push and pop, across pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 2'd0, 1'b0);
      chk("full_pp_level", 32'(level), 32'd16);
    end
    chk("full_pp_overflow", 32'(overflow), 32'd0);
    chk("full_pp_drop_cnt", 32'(drop_cnt), 32'(exp_drops()));
    drain();

    // mode change: earlier bytes keep the old mapping
    drive(1'b1, 8'h71, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h6D, 1'b0, 1'b1, 2'd3, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h7A, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h35, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("mode_head", 32'(out_data), 32'h51);
    drain();

    // clear coinciding with a drop: set wins
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("clr_vs_drop", 32'(overflow), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("clr_after", 32'(overflow), 32'd0);
    drain();

    // random backpressure, FIFO kept below full
    sent = 0;
    for (int c = 0; c < 8000 && sent < 1000; c++) begin
      logic v;
      v = ($urandom_range(1) == 1) && (sb.size() < 14);
      b = 8'($urandom_range(255));
      drive(v, b, 1'($urandom_range(1)), 1'b0, 2'd0, 1'b0);
      if (v) sent++;
    end
    chk("bp_sent", 32'(sent), 32'd1000);
    drain();
    chk("bp_no_overflow", 32'(overflow), 32'd0);

    // reset in mid-stream
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h40, 1'b0, 1'b0, 2'd0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("mid_rst_hwm", 32'(hwm), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    drive(1'b1, 8'h62, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h42);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
